// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one request becomes a linear incrementing burst,
// with write data from a valid/ready stream and read data to a valid/ready stream.
module wb_burst_master #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  // request
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [AW-1:0]                  req_addr,
  input  logic [$clog2(MAX_BURST)-1:0]   req_len,
  // write stream
  input  logic                           wdata_valid,
  output logic                           wdata_ready,
  input  logic [DW-1:0]                  wdata,
  input  logic [DW/8-1:0]                wsel,
  // read stream
  output logic                           rdata_valid,
  input  logic                           rdata_ready,
  output logic [DW-1:0]                  rdata,
  // completion
  output logic                           done_valid,
  output logic                           done_err,
  // wishbone
  output logic [AW-1:0]                  wb_adr_o,
  output logic [DW-1:0]                  wb_dat_o,
  output logic [DW/8-1:0]                wb_sel_o,
  output logic                           wb_we_o,
  output logic                           wb_cyc_o,
  output logic                           wb_stb_o,
  output logic [2:0]                     wb_cti_o,
  output logic [1:0]                     wb_bte_o,
  input  logic                           wb_ack_i,
  input  logic                           wb_err_i,
  input  logic                           wb_rty_i,
  input  logic [DW-1:0]                  wb_dat_i
);

  localparam int unsigned SW   = DW / 8;
  localparam int unsigned LW   = $clog2(MAX_BURST);
  localparam int unsigned RemW = LW + 1;
  localparam int unsigned RW   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StBurst  = 2'd1;
  localparam logic [1:0] StRtyGap = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [RemW-1:0] RemZero = '0;
  localparam logic [RemW-1:0] RemOne  = RemW'(1);
  localparam logic [RW-1:0]   RtyOne  = RW'(1);
  localparam logic [RW-1:0]   RtyMax  = RW'(RETRY_MAX);
  localparam logic [AW-1:0]   AdrStep = AW'(SW);

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   adr_q;
  logic [RemW-1:0] rem_q;
  logic            single_q;
  logic            we_q;
  logic [RW-1:0]   retries_q;
  logic            err_q;

  logic            wfull_q;
  logic [DW-1:0]   wdat_q;
  logic [SW-1:0]   wsel_q;
  logic [RemW-1:0] drain_q;

  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;

  logic in_burst;
  logic stb;
  logic t_ack;
  logic t_err;
  logic t_rty;
  logic retry_ok;
  logic fail;
  logic last;
  logic accept;
  logic draining;
  logic wr_ready_burst;
  logic wload;

  always_comb begin
    in_burst = (state_q == StBurst);
    accept   = (state_q == StIdle) & req_valid;
    stb      = in_burst & (we_q ? wfull_q : (~rvalid_q | rdata_ready));
    // Terminations only count while strobing; err beats rty beats ack.
    t_err    = stb & wb_err_i;
    t_rty    = stb & wb_rty_i & ~wb_err_i;
    t_ack    = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;
    retry_ok = (retries_q < RtyMax);
    fail     = t_err | (t_rty & ~retry_ok);
    last     = (rem_q == RemOne);
    draining = (drain_q != RemZero);
    // One-entry register: refill only when it frees up and beats remain unloaded.
    wr_ready_burst = in_burst & we_q & ~draining &
                     (wfull_q ? (t_ack & (rem_q > RemOne)) : (rem_q != RemZero));
    wload    = wdata_valid & wr_ready_burst;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StBurst;
      StBurst: begin
        if (fail)                state_d = StDone;
        else if (t_rty)          state_d = StRtyGap;
        else if (t_ack && last)  state_d = StDone;
      end
      StRtyGap: state_d = StBurst;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= StIdle;
      adr_q     <= '0;
      rem_q     <= '0;
      single_q  <= 1'b0;
      we_q      <= 1'b0;
      retries_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        adr_q     <= req_addr;
        rem_q     <= RemW'(req_len) + RemOne;
        single_q  <= (req_len == '0);
        we_q      <= req_we;
        retries_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (t_ack) begin
          adr_q <= adr_q + AdrStep;
          rem_q <= rem_q - RemOne;
        end
        if (t_rty && retry_ok) retries_q <= retries_q + RtyOne;
        if (fail) err_q <= 1'b1;
      end
    end
  end

  // Write beat register plus a discard counter that swallows the unsent beats
  // of a failed write so the stream stays aligned with the next request.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wfull_q <= 1'b0;
      wdat_q  <= '0;
      wsel_q  <= '0;
      drain_q <= '0;
    end else begin
      if (fail) begin
        wfull_q <= 1'b0;
      end else if (wload) begin
        wfull_q <= 1'b1;
        wdat_q  <= wdata;
        wsel_q  <= wsel;
      end else if (t_ack && we_q) begin
        wfull_q <= 1'b0;
      end

      if (fail && we_q) begin
        drain_q <= rem_q - RemOne;
      end else if (draining && wdata_valid) begin
        drain_q <= drain_q - RemOne;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (t_ack && !we_q) begin
      rvalid_q <= 1'b1;
      rdata_q  <= wb_dat_i;
    end else if (rdata_ready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_comb begin
    req_ready   = (state_q == StIdle);
    wdata_ready = wr_ready_burst | draining;
    rdata_valid = rvalid_q;
    rdata       = rdata_q;
    done_valid  = (state_q == StDone);
    done_err    = (state_q == StDone) & err_q;

    wb_adr_o = adr_q;
    wb_dat_o = wdat_q;
    wb_we_o  = in_burst & we_q;
    wb_cyc_o = in_burst;
    wb_stb_o = stb;
    wb_bte_o = 2'b00;

    if (!in_burst)  wb_sel_o = '0;
    else if (we_q)  wb_sel_o = wsel_q;
    else            wb_sel_o = '1;

    if (!in_burst || single_q) wb_cti_o = 3'b000;
    else if (last)             wb_cti_o = 3'b111;
    else                       wb_cti_o = 3'b010;
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: the bench plays the Wishbone slave and
// both streams, checking bus and stream outputs against hand-derived values.
module tb_wb_burst_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic        done_valid;
  logic        done_err;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        we_o;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;
  logic [31:0] dat_i;

  int n_vec = 0;
  int n_err = 0;

  wb_burst_master dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .wsel        (wsel),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .done_valid  (done_valid),
    .done_err    (done_err),
    .wb_adr_o    (adr),
    .wb_dat_o    (dat_o),
    .wb_sel_o    (sel),
    .wb_we_o     (we_o),
    .wb_cyc_o    (cyc),
    .wb_stb_o    (stb),
    .wb_cti_o    (cti),
    .wb_bte_o    (bte),
    .wb_ack_i    (ack),
    .wb_err_i    (err),
    .wb_rty_i    (rty),
    .wb_dat_i    (dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic we, input logic [31:0] a, input logic [3:0] len);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = len;
    settle();
    chk("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
    wdata_valid = 0; wdata = '0; wsel = '0; rdata_ready = 0;
    ack = 0; err = 0; rty = 0; dat_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_wready", wdata_ready, 0);
    chk("rst_adr", adr, 0);
    chk("rst_sel", sel, 0);
    chk("rst_cti", cti, 0);
    chk("rst_bte", bte, 0);
    rst_n = 1'b1;
    tick();

    // 4-beat write at 0x100, ack every cycle
    request(1'b1, 32'h100, 4'd3);
    wdata_valid = 1; wdata = 32'hA0; wsel = 4'hF;
    settle();
    chk("w4_stb_empty", stb, 0);
    chk("w4_cyc", cyc, 1);
    chk("w4_wready_first", wdata_ready, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      wdata_valid = (i < 3);
      wdata = 32'hA1 + i;
      ack = 1;
      settle();
      chk("w4_stb", stb, 1);
      chk("w4_we", we_o, 1);
      chk("w4_adr", adr, 32'h100 + 4 * i);
      chk("w4_dat", dat_o, 32'hA0 + i);
      chk("w4_sel", sel, 4'hF);
      chk("w4_cti", cti, (i == 3) ? 3'b111 : 3'b010);
      chk("w4_wready", wdata_ready, (i < 3) ? 1 : 0);
      tick();
    end
    ack = 0; wdata_valid = 0;
    settle();
    chk("w4_done", done_valid, 1);
    chk("w4_done_err", done_err, 0);
    chk("w4_cyc_done", cyc, 0);
    tick();
    settle();
    chk("w4_done_clear", done_valid, 0);

    // 4-beat read with rdata_ready low for 3 cycles mid-burst
    rdata_ready = 1;
    request(1'b0, 32'h100, 4'd3);
    ack = 1; dat_i = 32'hA0;
    settle();
    chk("r4_stb0", stb, 1);
    chk("r4_adr0", adr, 32'h100);
    chk("r4_sel", sel, 4'hF);
    chk("r4_we", we_o, 0);
    chk("r4_cti0", cti, 3'b010);
    tick();
    dat_i = 32'hA1;
    settle();
    chk("r4_rvalid1", rdata_valid, 1);
    chk("r4_rdata0", rdata, 32'hA0);
    chk("r4_adr1", adr, 32'h104);
    tick();
    rdata_ready = 0; ack = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("r4_stall_stb", stb, 0);
      chk("r4_stall_rvalid", rdata_valid, 1);
      chk("r4_stall_rdata", rdata, 32'hA1);
      tick();
    end
    rdata_ready = 1; ack = 1; dat_i = 32'hA2;
    settle();
    chk("r4_resume_stb", stb, 1);
    chk("r4_adr2", adr, 32'h108);
    chk("r4_cti2", cti, 3'b010);
    chk("r4_rdata1", rdata, 32'hA1);
    tick();
    dat_i = 32'hA3;
    settle();
    chk("r4_adr3", adr, 32'h10C);
    chk("r4_cti3", cti, 3'b111);
    chk("r4_rdata2", rdata, 32'hA2);
    tick();
    ack = 0;
    settle();
    chk("r4_done", done_valid, 1);
    chk("r4_done_err", done_err, 0);
    chk("r4_rdata3", rdata, 32'hA3);
    chk("r4_rvalid3", rdata_valid, 1);
    tick();
    settle();
    chk("r4_rvalid_clear", rdata_valid, 0);

    // Single write with partial byte select
    request(1'b1, 32'h200, 4'd0);
    wdata_valid = 1; wdata = 32'h1122_3344; wsel = 4'b0010;
    settle();
    chk("w1_wready", wdata_ready, 1);
    tick();
    wdata_valid = 0; ack = 1;
    settle();
    chk("w1_stb", stb, 1);
    chk("w1_cti", cti, 3'b000);
    chk("w1_sel", sel, 4'b0010);
    chk("w1_adr", adr, 32'h200);
    chk("w1_dat", dat_o, 32'h1122_3344);
    chk("w1_wready_last", wdata_ready, 0);
    tick();
    ack = 0;
    settle();
    chk("w1_done", done_valid, 1);
    chk("w1_done_err", done_err, 0);
    chk("w1_cyc", cyc, 0);
    tick();

    // RTY on beat 2 of a 4-beat write, then OK
    request(1'b1, 32'h300, 4'd3);
    wdata_valid = 1; wdata = 32'hB0; wsel = 4'hF;
    tick();
    ack = 1; wdata = 32'hB1;
    tick();
    wdata = 32'hB2;
    settle();
    chk("rty_adr1", adr, 32'h304);
    tick();
    ack = 0; rty = 1; wdata = 32'hB3;
    settle();
    chk("rty_adr2", adr, 32'h308);
    chk("rty_dat2", dat_o, 32'hB2);
    chk("rty_wready", wdata_ready, 0);
    tick();
    rty = 0;
    settle();
    chk("rty_gap_cyc", cyc, 0);
    chk("rty_gap_stb", stb, 0);
    chk("rty_gap_wready", wdata_ready, 0);
    tick();
    ack = 1;
    settle();
    chk("rty_resume_stb", stb, 1);
    chk("rty_resume_adr", adr, 32'h308);
    chk("rty_resume_dat", dat_o, 32'hB2);
    chk("rty_resume_cti", cti, 3'b010);
    chk("rty_resume_wready", wdata_ready, 1);
    tick();
    wdata_valid = 0;
    settle();
    chk("rty_last_adr", adr, 32'h30C);
    chk("rty_last_dat", dat_o, 32'hB3);
    chk("rty_last_cti", cti, 3'b111);
    tick();
    ack = 0;
    settle();
    chk("rty_done", done_valid, 1);
    chk("rty_done_err", done_err, 0);
    tick();

    // ERR on beat 1 of a 4-beat write; remaining beats are drained
    request(1'b1, 32'h400, 4'd3);
    wdata_valid = 1; wdata = 32'hC0;
    tick();
    ack = 1; wdata = 32'hC1;
    settle();
    chk("err_adr0", adr, 32'h400);
    tick();
    ack = 0; err = 1; wdata = 32'hC2;
    settle();
    chk("err_adr1", adr, 32'h404);
    chk("err_dat1", dat_o, 32'hC1);
    chk("err_wready_hold", wdata_ready, 0);
    tick();
    err = 0;
    settle();
    chk("err_done", done_valid, 1);
    chk("err_done_err", done_err, 1);
    chk("err_cyc", cyc, 0);
    chk("err_drain1", wdata_ready, 1);
    tick();
    wdata = 32'hC3;
    settle();
    chk("err_drain2", wdata_ready, 1);
    chk("err_idle", req_ready, 1);
    tick();
    wdata_valid = 0;
    settle();
    chk("err_drain_end", wdata_ready, 0);

    // Retry limit: four RTYs on a single read, last one alongside ack
    rdata_ready = 1;
    request(1'b0, 32'h600, 4'd0);
    for (int k = 0; k < 3; k++) begin
      rty = 1;
      settle();
      chk("rlim_stb", stb, 1);
      chk("rlim_cti", cti, 3'b000);
      tick();
      rty = 0;
      settle();
      chk("rlim_gap", cyc, 0);
      tick();
    end
    rty = 1; ack = 1;
    settle();
    chk("rlim_last_stb", stb, 1);
    tick();
    rty = 0; ack = 0;
    settle();
    chk("rlim_done", done_valid, 1);
    chk("rlim_done_err", done_err, 1);
    chk("rlim_no_capture", rdata_valid, 0);
    tick();

    // Reset asserted mid read burst
    rdata_ready = 0;
    request(1'b0, 32'h100, 4'd3);
    ack = 1; dat_i = 32'hA0;
    settle();
    chk("mrst_stb", stb, 1);
    tick();
    ack = 0;
    settle();
    chk("mrst_rvalid", rdata_valid, 1);
    chk("mrst_cyc", cyc, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_cyc0", cyc, 0);
    chk("mrst_stb0", stb, 0);
    chk("mrst_rvalid0", rdata_valid, 0);
    chk("mrst_done0", done_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("mrst_ready", req_ready, 1);
    chk("mrst_no_done", done_valid, 0);
    rdata_ready = 1;
    request(1'b0, 32'h500, 4'd0);
    ack = 1; dat_i = 32'hDEAD_BEEF;
    settle();
    chk("post_stb", stb, 1);
    chk("post_cti", cti, 3'b000);
    chk("post_adr", adr, 32'h500);
    tick();
    ack = 0;
    settle();
    chk("post_done", done_valid, 1);
    chk("post_done_err", done_err, 0);
    chk("post_rvalid", rdata_valid, 1);
    chk("post_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    settle();
    chk("post_rvalid_clear", rdata_valid, 0);
    chk("post_idle", req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
